// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - per-channel key debouncer with press/release pulses; long-press pulse under KEY_LONG_PRESS_EN
module key_debounce_multi #(
    parameter int unsigned KEY_NUM  = 4,
    parameter int unsigned CNT_MAX  = 999_999,
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned LONG_MAX = 49_999_999,
    parameter int unsigned LONG_W   = 26
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] press_pulse,
    output logic [KEY_NUM-1:0] release_pulse,
    output logic [KEY_NUM-1:0] long_pulse
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        PRESSED    = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CNT_MAX);

    if (KEY_NUM < 1 || KEY_NUM > 16 || CNT_MAX < 1 ||
        (64'(CNT_MAX) >> CNT_W) != 64'd0 ||
        (64'(LONG_MAX) >> LONG_W) != 64'd0) begin : g_bad_cfg
        $error("key_debounce_multi: illegal parameter set");
    end

    logic [KEY_NUM-1:0] sync1;
    logic [KEY_NUM-1:0] sync2;
    state_t             state [KEY_NUM];
    logic [CNT_W-1:0]   cnt   [KEY_NUM];

    // Synchroniser resets to 1 so a released key looks idle straight out of reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_END = LONG_W'(LONG_MAX);

    logic [LONG_W-1:0]  long_cnt [KEY_NUM];
    logic [KEY_NUM-1:0] long_done;
`else
    assign long_pulse = '0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < KEY_NUM; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
`ifdef KEY_LONG_PRESS_EN
                long_cnt[i] <= '0;
`endif
            end
            key_state     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
`ifdef KEY_LONG_PRESS_EN
            long_done  <= '0;
            long_pulse <= '0;
`endif
        end else begin
            press_pulse   <= '0;
            release_pulse <= '0;
`ifdef KEY_LONG_PRESS_EN
            long_pulse <= '0;
`endif
            for (int i = 0; i < KEY_NUM; i++) begin
                case (state[i])
                    IDLE: begin
                        if (!sync2[i]) begin
                            state[i] <= PRESS_FILT;
                            cnt[i]   <= '0;
                        end
                    end
                    PRESS_FILT: begin
                        if (sync2[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_END) begin
                            state[i]       <= PRESSED;
                            key_state[i]   <= 1'b1;
                            press_pulse[i] <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
                            long_cnt[i]  <= '0;
                            long_done[i] <= 1'b0;
`endif
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (sync2[i]) begin
                            state[i] <= REL_FILT;
                            cnt[i]   <= '0;
                        end
`ifdef KEY_LONG_PRESS_EN
                        // long_done keeps a held counter from re-firing the pulse.
                        else if (long_cnt[i] == LONG_END) begin
                            if (!long_done[i]) begin
                                long_pulse[i] <= 1'b1;
                                long_done[i]  <= 1'b1;
                            end
                        end else begin
                            long_cnt[i] <= long_cnt[i] + 1'b1;
                        end
`endif
                    end
                    REL_FILT: begin
                        if (!sync2[i]) begin
                            state[i] <= PRESSED;
                        end else if (cnt[i] == CNT_END) begin
                            state[i]         <= IDLE;
                            key_state[i]     <= 1'b0;
                            release_pulse[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - directed vector bench for key_debounce_multi
module tb_key_debounce_multi;

`ifdef KEY_LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif
    localparam logic [3:0] LP0 = LP ? 4'b0001 : 4'b0000;
    localparam int NV = 21;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] key_in  = 4'hF;
    logic [3:0] key_state;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_pulse;

    key_debounce_multi #(
        .KEY_NUM (4),
        .CNT_MAX (9),
        .CNT_W   (4),
        .LONG_MAX(49),
        .LONG_W  (6)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_in       (key_in),
        .key_state    (key_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0] key;
        int         n;
        logic [3:0] st;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] l;
    } vec_t;

    vec_t tbl [NV];

    int checks = 0;
    int errors = 0;
    int press_cnt [4];
    int rel_cnt   [4];
    int long_cnt  [4];
    logic [3:0] prev_p = '0;
    logic [3:0] prev_r = '0;
    logic [3:0] prev_l = '0;

    // Pulse tally and back-to-back pulse watch, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            for (int i = 0; i < 4; i++) begin
                if (press_pulse[i])   press_cnt[i]++;
                if (release_pulse[i]) rel_cnt[i]++;
                if (long_pulse[i])    long_cnt[i]++;
            end
            checks++;
            if (((press_pulse & prev_p) | (release_pulse & prev_r) | (long_pulse & prev_l)) != 4'b0) begin
                errors++;
                $display("FAIL back_to_back_pulse: p=%b r=%b l=%b prev p=%b r=%b l=%b required no overlap",
                         press_pulse, release_pulse, long_pulse, prev_p, prev_r, prev_l);
            end
        end
        prev_p = press_pulse;
        prev_r = release_pulse;
        prev_l = long_pulse;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] st, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] l);
        chk(name, {16'h0, key_state, press_pulse, release_pulse, long_pulse}, {16'h0, st, p, r, l});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            long_cnt[i]  = 0;
        end
        // {key_in, steps, key_state, press, release, long}
        tbl[0]  = '{4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{4'hE, 12, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{4'hE,  1, 4'h1, 4'h1, 4'h0, 4'h0};
        tbl[3]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[4]  = '{4'hE, 48, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[5]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, LP0};
        tbl[6]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[7]  = '{4'hE, 48, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[8]  = '{4'hF, 12, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[9]  = '{4'hF,  1, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[10] = '{4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[11] = '{4'hD,  5, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[12] = '{4'hF, 20, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[13] = '{4'hB,  9, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[14] = '{4'hF, 20, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[15] = '{4'h6, 12, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[16] = '{4'h6,  1, 4'h9, 4'h9, 4'h0, 4'h0};
        tbl[17] = '{4'h6,  1, 4'h9, 4'h0, 4'h0, 4'h0};
        tbl[18] = '{4'hF, 12, 4'h9, 4'h0, 4'h0, 4'h0};
        tbl[19] = '{4'hF,  1, 4'h0, 4'h0, 4'h9, 4'h0};
        tbl[20] = '{4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0};

        step(3);
        chk_out("reset_state", 4'h0, 4'h0, 4'h0, 4'h0);
        sys_rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            key_in = tbl[k].key;
            step(tbl[k].n);
            chk_out($sformatf("vec%0d", k), tbl[k].st, tbl[k].p, tbl[k].r, tbl[k].l);
        end
        chk("tbl_press_ch0", press_cnt[0], 2);
        chk("tbl_rel_ch0",   rel_cnt[0],   2);
        chk("tbl_long_ch0",  long_cnt[0],  LP ? 1 : 0);
        chk("tbl_press_ch1", press_cnt[1], 0);
        chk("tbl_press_ch2", press_cnt[2], 0);
        chk("tbl_press_ch3", press_cnt[3], 1);
        chk("tbl_rel_ch3",   rel_cnt[3],   1);

        // Bounce on key 1, ending high, then a clean press.
        for (int i = 0; i < 40; i++) begin
            key_in[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        chk("bounce_no_press", press_cnt[1], 0);
        key_in = 4'hD;
        step(12);
        chk_out("bounce_pre", 4'h0, 4'h0, 4'h0, 4'h0);
        step(1);
        chk_out("bounce_press", 4'h2, 4'h2, 4'h0, 4'h0);
        key_in = 4'hF;
        step(13);
        chk_out("bounce_release", 4'h0, 4'h0, 4'h2, 4'h0);
        chk("bounce_press_cnt", press_cnt[1], 1);

        // Key 2 held 200 cycles: one press, one long pulse 50 cycles later.
        key_in = 4'hB;
        step(12);
        chk_out("long_pre", 4'h0, 4'h0, 4'h0, 4'h0);
        step(1);
        chk_out("long_press", 4'h4, 4'h4, 4'h0, 4'h0);
        step(49);
        chk_out("long_early", 4'h4, 4'h0, 4'h0, 4'h0);
        step(1);
        chk_out("long_fire", 4'h4, 4'h0, 4'h0, LP ? 4'h4 : 4'h0);
        step(137);
        chk("long_cnt_ch2",  long_cnt[2],  LP ? 1 : 0);
        chk("long_press_ch2", press_cnt[2], 1);
        key_in = 4'hF;
        step(13);
        chk_out("long_release", 4'h0, 4'h0, 4'h4, 4'h0);

        // Key 3: short release bounce freezes the long counter for 4 edges.
        key_in = 4'h7;
        step(13);
        chk_out("relbounce_press", 4'h8, 4'h8, 4'h0, 4'h0);
        step(10);
        key_in = 4'hF;
        step(3);
        key_in = 4'h7;
        step(40);
        chk("relbounce_no_long", long_cnt[3], 0);
        chk("relbounce_no_rel",  rel_cnt[3],  1);
        chk_out("relbounce_held", 4'h8, 4'h0, 4'h0, 4'h0);
        step(1);
        chk_out("relbounce_long", 4'h8, 4'h0, 4'h0, LP ? 4'h8 : 4'h0);
        step(1);
        chk_out("relbounce_after", 4'h8, 4'h0, 4'h0, 4'h0);
        key_in = 4'hF;
        step(13);
        chk_out("relbounce_release", 4'h0, 4'h0, 4'h8, 4'h0);

        // Reset while key 0 is pressed, then re-detection with full latency.
        key_in = 4'hE;
        step(13);
        chk_out("rst_press", 4'h1, 4'h1, 4'h0, 4'h0);
        step(5);
        sys_rst = 1'b1;
        #1;
        chk_out("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
        step(2);
        sys_rst = 1'b0;
        step(12);
        chk_out("rst_redetect_pre", 4'h0, 4'h0, 4'h0, 4'h0);
        step(1);
        chk_out("rst_redetect", 4'h1, 4'h1, 4'h0, 4'h0);
        key_in = 4'hF;
        step(13);
        chk_out("rst_release", 4'h0, 4'h0, 4'h1, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 SHALL provide parameter KEY_NUM, default 4, number of independent key channels (1..16).
REQ-002 SHALL provide parameter CNT_MAX, default 20'd999_999, debounce window in clock cycles minus one (20 ms at 50 MHz).
REQ-003 SHALL provide parameter CNT_W, default 20, width of the debounce counter; CNT_MAX SHALL fit in CNT_W bits and SHALL be at least 1.
REQ-004 SHALL provide parameter LONG_MAX, default 26'd49_999_999, long-press threshold in cycles minus one (1 s at 50 MHz).
REQ-005 SHALL provide parameter LONG_W, default 26, width of the long-press counter.
REQ-006 sys_clk  input  1  sole clock; all flops clock on its rising edge.
REQ-007 sys_rst  input  1  reset, asynchronous, active-high.
REQ-008 key_in  input  KEY_NUM  raw asynchronous keys, active-low (0 = pressed).
REQ-009 key_state  output  KEY_NUM  debounced level per channel, 1 = pressed.
REQ-010 press_pulse  output  KEY_NUM  one-cycle pulse on a debounced press.
REQ-011 release_pulse  output  KEY_NUM  one-cycle pulse on a debounced release.
REQ-012 long_pulse  output  KEY_NUM  one-cycle pulse when a press is held past the long-press threshold.

Function
REQ-013 Each key_in bit SHALL pass through a 2-flop synchroniser before use; channels SHALL be fully independent.
REQ-014 Each channel SHALL run an FSM with the states IDLE, PRESS_FILT, PRESSED and REL_FILT.
REQ-015 IDLE: synced input 0 -> PRESS_FILT with cnt=0; otherwise stay.
REQ-016 PRESS_FILT: synced 1 -> IDLE with cnt=0; synced 0 and cnt<CNT_MAX -> cnt+1; synced 0 and cnt==CNT_MAX -> PRESSED, key_state<=1, press_pulse<=1 for one cycle, long_cnt=0.
REQ-017 PRESSED: synced 1 -> REL_FILT with cnt=0; otherwise long_cnt increments until ==LONG_MAX, at which point long_pulse<=1 for one cycle and long_cnt holds (exactly one long_pulse per press).
REQ-018 REL_FILT: synced 0 -> PRESSED (long_cnt held, not cleared); synced 1 and cnt<CNT_MAX -> cnt+1; synced 1 and cnt==CNT_MAX -> IDLE, key_state<=0, release_pulse<=1 for one cycle.
REQ-019 long_cnt SHALL NOT advance while in REL_FILT.
REQ-020 Latency: press_pulse SHALL assert CNT_MAX+3 edges after the edge that first samples key_in low (stable); release_pulse likewise after key_in returns high.
REQ-021 long_pulse SHALL assert LONG_MAX+1 cycles after press_pulse when the key is held without bounce.
REQ-022 All outputs SHALL be registered; the pulses SHALL never be high for two consecutive cycles on one channel.
REQ-023 Simultaneous events on different channels SHALL produce pulses in the same cycle with no interaction.
REQ-024 A glitch shorter than CNT_MAX+1 cycles SHALL produce no pulse and no key_state change.

Reset
REQ-025 While sys_rst=1: synchroniser flops=1 (released), all FSMs=IDLE, cnt=0, long_cnt=0, key_state=0, all pulses=0.
REQ-026 Reset mid-operation SHALL abort any filter or press in progress; a key still held after reset release SHALL be re-detected with full REQ-020 latency.

Configuration
REQ-027 Macro KEY_LONG_PRESS_EN: when defined, long_cnt and the long_pulse logic are built per REQ-017/021.
REQ-028 Without KEY_LONG_PRESS_EN: no long_cnt is instantiated, long_pulse is tied to 0, and all other behaviour is unchanged.

Verification (KEY_NUM=4, CNT_MAX=9, CNT_W=4, LONG_MAX=49, LONG_W=6, macro defined)
REQ-029 key_in[0] 1->0 held -> press_pulse[0] high exactly at edge 12 for 1 cycle, key_state[0]=1; release after 100 cycles -> release_pulse[0] 12 edges later, key_state[0]=0.
REQ-030 key_in[1] low for 5 cycles, then high -> no pulses, key_state[1] stays 0; bounce 0/1 every 3 cycles for 40 cycles, then stable low -> exactly one press_pulse[1].
REQ-031 key_in[2] held low for 200 cycles -> press_pulse[2] once, long_pulse[2] once 50 cycles later, none thereafter.
REQ-032 keys 0 and 3 pressed on the same edge -> press_pulse=4'b1001 in one cycle.
REQ-033 sys_rst pulsed while key_in[0] held and PRESSED -> outputs 0 immediately; after release of reset, press_pulse[0] reasserts 12 edges later.
REQ-034 Rebuild without KEY_LONG_PRESS_EN, repeat REQ-031 -> long_pulse stays 4'b0000, press/release timing unchanged.
